// File: rtl/gate_truth_table_checker_pkg.sv
// gate_truth_table_checker_pkg: shared state encoding and common two-input truth tables
package gate_truth_table_checker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_NOR2  = 4'b0001;
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_XOR2  = 4'b0110;

endpackage

// File: rtl/gate_truth_table_checker_settle_counter.sv
// gate_truth_table_checker_settle_counter: counts settle edges, flags the last one before sampling
module gate_truth_table_checker_settle_counter #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [3:0] count;

    // tc is high on the edge that completes SETTLE_CYCLES settle edges
    assign tc = (int'(count) + 1 >= SETTLE_CYCLES);

    // clear wins over count so each vector starts its settle window from zero
    always_ff @(posedge clk or posedge rst)
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 4'd1;

endmodule

// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker: walks every input vector of a gate cell and scores its output against a truth table
module gate_truth_table_checker
    import gate_truth_table_checker_pkg::*;
#(
    parameter int                   N_IN          = 2,
    parameter int                   SETTLE_CYCLES = 2,
    parameter logic [2**N_IN-1:0]   EXPECTED      = TT_NAND2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic [N_IN-1:0]               gate_in,
    input  logic                          gate_out,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [2**N_IN-1:0]            fail_vec,
    output logic [$clog2(2**N_IN+1)-1:0]  fail_count
);

    localparam int CW = $clog2(2**N_IN+1);
    localparam state_t VEC_FIRST = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_t state, state_nxt;
    logic   tc, last, mismatch, accept;

    assign accept   = (state == IDLE) && start;
    assign last     = &gate_in;
    assign mismatch = (gate_out !== EXPECTED[gate_in]);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    gate_truth_table_checker_settle_counter #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
        .clk (clk),
        .rst (rst),
        .clr (state != SETTLE),
        .en  (state == SETTLE),
        .tc  (tc)
    );

    // next-state: one settle window then one sample per vector, DONE after the last vector
    always_comb begin
        state_nxt = (state == IDLE)   ? (start ? VEC_FIRST : IDLE) :
                    (state == SETTLE) ? (tc ? SAMPLE : SETTLE) :
                    (state == SAMPLE) ? (last ? DONE : VEC_FIRST) : IDLE;
    end

    // state, vector index (gate_in) and scoreboard; results hold in IDLE until the next accepted start
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= IDLE;
            gate_in    <= '0;
            fail_vec   <= '0;
            fail_count <= '0;
            pass       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                gate_in    <= '0;
                fail_vec   <= '0;
                fail_count <= '0;
                pass       <= 1'b0;
            end
            if (state == SAMPLE) begin
                if (mismatch) begin
                    fail_vec[gate_in] <= 1'b1;
                    fail_count        <= fail_count + CW'(1);
                end
                if (!last)
                    gate_in <= gate_in + N_IN'(1);
                else
                    pass <= (fail_count == '0) && !mismatch;
            end
        end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// tb_gate_truth_table_checker: table-driven and randomized checks of the gate truth-table sequencer
module tb_gate_truth_table_checker;
    import gate_truth_table_checker_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic [3:0] tt0 = TT_NAND2;
    logic [1:0] gate_in0, gate_in1, gate_in2;
    logic       gate_out0, gate_out1, gate_out2;
    logic       busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
    logic [3:0] fail_vec0, fail_vec1, fail_vec2;
    logic [2:0] fail_count0, fail_count1, fail_count2;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    assign gate_out0 = tt0[gate_in0];
    assign gate_out1 = ~&gate_in1;
    assign gate_out2 = ~&gate_in2;

    gate_truth_table_checker u0 (
        .clk(clk), .rst(rst), .start(start0), .gate_in(gate_in0), .gate_out(gate_out0),
        .busy(busy0), .done(done0), .pass(pass0), .fail_vec(fail_vec0), .fail_count(fail_count0)
    );

    gate_truth_table_checker #(.EXPECTED(TT_AND2)) u1 (
        .clk(clk), .rst(rst), .start(start1), .gate_in(gate_in1), .gate_out(gate_out1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_vec(fail_vec1), .fail_count(fail_count1)
    );

    gate_truth_table_checker #(.SETTLE_CYCLES(0)) u2 (
        .clk(clk), .rst(rst), .start(start2), .gate_in(gate_in2), .gate_out(gate_out2),
        .busy(busy2), .done(done2), .pass(pass2), .fail_vec(fail_vec2), .fail_count(fail_count2)
    );

    typedef struct {
        string      name;
        logic [3:0] tt;
        logic [3:0] exp_fv;
        int         exp_cnt;
        logic       exp_pass;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    // one full default-parameter run; vector k occupies edges 3k+1..3k+3, done after E12
    task automatic run0(input string nm, input logic [3:0] tt, input logic [3:0] exp_fv,
                        input int exp_cnt, input logic exp_pass);
        tt0 = tt;
        @(negedge clk) start0 = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 13; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk) start0 = 1'b0;
            chk($sformatf("%s gate_in k=%0d", nm, k), gate_in0, (k < 12) ? k / 3 : 3);
            chk($sformatf("%s done k=%0d", nm, k), done0, k == 12);
            chk($sformatf("%s busy k=%0d", nm, k), busy0, k <= 12);
            if (k == 0) chk({nm, " cleared fail_count"}, fail_count0, 0);
            if (k == 12) begin
                chk({nm, " fail_vec"}, fail_vec0, exp_fv);
                chk({nm, " fail_count"}, fail_count0, exp_cnt);
                chk({nm, " pass"}, pass0, exp_pass);
            end
            if (k == 13) chk({nm, " fail_vec held"}, fail_vec0, exp_fv);
        end
    endtask

    initial begin
        vec_t tab[5];
        tab[0] = '{"nand", TT_NAND2, 4'b0000, 0, 1'b1};
        tab[1] = '{"tied1", 4'b1111, 4'b1000, 1, 1'b0};
        tab[2] = '{"tied0", 4'b0000, 4'b0111, 3, 1'b0};
        tab[3] = '{"xor", TT_XOR2, 4'b0001, 1, 1'b0};
        tab[4] = '{"nor", TT_NOR2, 4'b0110, 2, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset busy", busy0, 0);
        chk("reset done", done0, 0);
        chk("reset pass", pass0, 0);
        chk("reset fail_vec", fail_vec0, 0);
        chk("reset fail_count", fail_count0, 0);
        chk("reset gate_in", gate_in0, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            run0(tab[i].name, tab[i].tt, tab[i].exp_fv, tab[i].exp_cnt, tab[i].exp_pass);

        // randomized truth tables; reference: mismatch set is tt xor NAND, count is its popcount
        for (int r = 0; r < 8; r++) begin
            logic [3:0] tt, fv;
            tt = 4'($urandom_range(0, 15));
            fv = tt ^ TT_NAND2;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run0($sformatf("rand%0d", r), tt, fv, $countones(fv), fv == 4'b0000);
        end

        // start held high: run 1 ends E12, run 2 accepted at E14
        tt0 = 4'b1111;
        @(negedge clk) start0 = 1'b1;
        for (int k = 0; k <= 27; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 19) start0 = 1'b0;
            if (k == 6) chk("held gate_in mid-run", gate_in0, 2);
            if (k == 12) chk("held done run1", done0, 1);
            if (k == 13) chk("held busy low", busy0, 0);
            if (k == 13) chk("held fail_vec idle", fail_vec0, 4'b1000);
            if (k == 14) chk("held busy run2", busy0, 1);
            if (k == 14) chk("held fail_vec cleared", fail_vec0, 0);
            if (k == 25) chk("held done early", done0, 0);
            if (k == 26) chk("held done run2", done0, 1);
            if (k == 26) chk("held fail_vec run2", fail_vec0, 4'b1000);
            if (k == 27) chk("held busy end", busy0, 0);
        end

        // asynchronous reset during vector 1 settle
        tt0 = TT_NAND2;
        @(negedge clk) start0 = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk) start0 = 1'b0;
        end
        chk("pre-rst gate_in", gate_in0, 1);
        #1 rst = 1'b1;
        #1;
        chk("async rst busy", busy0, 0);
        chk("async rst done", done0, 0);
        chk("async rst gate_in", gate_in0, 0);
        chk("async rst pass", pass0, 0);
        begin
            int seen = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                seen += done0;
            end
            chk("no done during rst", seen, 0);
        end
        rst = 1'b0;
        run0("after rst", TT_NAND2, 4'b0000, 0, 1'b1);

        // EXPECTED=AND against a nand cell: every vector mismatches
        @(negedge clk) start1 = 1'b1;
        for (int k = 0; k <= 13; k++) begin
            @(posedge clk);
            @(negedge clk) start1 = 1'b0;
            if (k == 12) begin
                chk("and done", done1, 1);
                chk("and fail_vec", fail_vec1, 4'b1111);
                chk("and fail_count", fail_count1, 4);
                chk("and pass", pass1, 0);
            end
        end

        // zero settle: one vector per edge, done after E4
        @(negedge clk) start2 = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk) start2 = 1'b0;
            if (k < 4) chk($sformatf("s0 gate_in k=%0d", k), gate_in2, k);
            chk($sformatf("s0 done k=%0d", k), done2, k == 4);
            if (k == 4) chk("s0 pass", pass2, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
